// File: rtl/mac_top.sv
// Signed fixed-point multiply-accumulate: Q1.7 product stage feeding a
// saturating accumulator, two-edge pipeline from A/B to O.
module mac_top #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 7
) (
    output logic [WIDTH-1:0] O,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CLK,
    input  logic             RESET
);

    localparam logic signed [2*WIDTH-1:0] PMAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] PMIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]          RMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]          RMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] full;
    logic signed [2*WIDTH-1:0] scaled;
    logic        [WIDTH-1:0]   p_next;
    logic        [WIDTH-1:0]   p;
    logic signed [WIDTH:0]     sum;
    logic        [WIDTH-1:0]   acc_next;
    logic        [WIDTH-1:0]   acc;

    // Product stage: full-precision multiply, arithmetic rescale, clamp.
    always_comb begin
        full   = $signed(A) * $signed(B);
        scaled = full >>> FRAC;
        if (scaled > PMAX)
            p_next = RMAX;
        else if (scaled < PMIN)
            p_next = RMIN;
        else
            p_next = scaled[WIDTH-1:0];
    end

    // Accumulate stage: one guard bit exposes overflow as sum[WIDTH] != sum[WIDTH-1].
    always_comb begin
        sum = $signed({acc[WIDTH-1], acc}) + $signed({p[WIDTH-1], p});
        if (sum[WIDTH] != sum[WIDTH-1])
            acc_next = sum[WIDTH] ? RMIN : RMAX;
        else
            acc_next = sum[WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p   <= '0;
            acc <= '0;
        end else begin
            p   <= p_next;
            acc <= acc_next;
        end
    end

    assign O = acc;

endmodule

// File: tb/tb_mac_top.sv
// Directed-vector bench for mac_top with hand-computed Q1.7 expectations.
module tb_mac_top;

    logic [7:0] O;
    logic [7:0] A;
    logic [7:0] B;
    logic       CLK;
    logic       RESET;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mac_top #(.WIDTH(8), .FRAC(7)) dut (
        .O(O), .A(A), .B(B), .CLK(CLK), .RESET(RESET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Apply a pair, take one rising edge, land 1 ns after it.
    task automatic step(input logic [7:0] a, input logic [7:0] b);
        A = a;
        B = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_async", O, 8'h00);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        A = 8'h00;
        B = 8'h00;
        #1;
        check("rst_init", O, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(8'($urandom), 8'($urandom));
            check("rst_hold", O, 8'h00);
        end
        RESET = 1'b0;

        // Basic sequence: products 0x20, 0x48, then 0xF0 held
        step(8'hC0, 8'hC0); check("basic0", O, 8'h00);
        step(8'hA0, 8'hA0); check("basic1", O, 8'h20);
        step(8'hC0, 8'h20); check("basic2", O, 8'h68);
        step(8'hC0, 8'h20); check("basic3", O, 8'h58);
        step(8'hC0, 8'h20); check("basic4", O, 8'h48);
        step(8'hC0, 8'h20); check("basic5", O, 8'h38);
        step(8'hC0, 8'h20); check("basic6", O, 8'h28);

        // Mid-run reset between edges
        do_reset();
        step(8'hC0, 8'hC0); check("mid0", O, 8'h00);
        step(8'hA0, 8'hA0); check("mid1", O, 8'h20);
        step(8'hC0, 8'h20); check("mid2", O, 8'h68);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_async", O, 8'h00);
        #2;
        RESET = 1'b0;
        step(8'hC0, 8'h20); check("mid_r0", O, 8'h00);
        step(8'hC0, 8'h20); check("mid_r1", O, 8'hF0);
        step(8'hC0, 8'h20); check("mid_r2", O, 8'hE0);

        // Positive saturation, then come off the rail
        do_reset();
        step(8'h7F, 8'h7F); check("psat0", O, 8'h00);
        step(8'h7F, 8'h7F); check("psat1", O, 8'h7E);
        step(8'h7F, 8'h7F); check("psat2", O, 8'h7F);
        step(8'h7F, 8'h7F); check("psat3", O, 8'h7F);
        step(8'h80, 8'h40); check("psat4", O, 8'h7F);
        step(8'h80, 8'h40); check("psat5", O, 8'h3F);
        step(8'h80, 8'h40); check("psat6", O, 8'hFF);

        // Negative saturation
        do_reset();
        step(8'h80, 8'h7F); check("nsat0", O, 8'h00);
        step(8'h80, 8'h7F); check("nsat1", O, 8'h81);
        step(8'h80, 8'h7F); check("nsat2", O, 8'h80);
        step(8'h80, 8'h7F); check("nsat3", O, 8'h80);

        // -1.0 * -1.0 clamps to 0x7F
        do_reset();
        step(8'h80, 8'h80); check("corner0", O, 8'h00);
        step(8'h00, 8'h00); check("corner1", O, 8'h7F);
        step(8'h00, 8'h00); check("corner2", O, 8'h7F);

        // Truncation toward -inf: 1 * -1 >>> 7 = -1
        do_reset();
        step(8'h01, 8'hFF); check("trunc0", O, 8'h00);
        step(8'h01, 8'hFF); check("trunc1", O, 8'hFF);
        step(8'h01, 8'hFF); check("trunc2", O, 8'hFE);
        step(8'h01, 8'hFF); check("trunc3", O, 8'hFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
